// File: rtl/timer_pkg.sv
// Shared types and constants for the 2-digit BCD countdown timer.
// State encoding is visible on the state output port.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a raw switch nibble to a legal BCD digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down-counter with sanitised load and decrement enable.
// Zero/one flags let the controller decide on RUN -> DONE.
module bcd_down_counter2
    import timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_preset,
    input  logic       i_dec,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_zero,
    output logic       o_one
);

    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       w_zero;

    assign w_zero = (r_tens == 4'd0) && (r_units == 4'd0);

    // Load takes priority; decrement borrows from tens and never passes 00.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (i_load) begin
            r_tens  <= bcd_sat(i_preset[7:4]);
            r_units <= bcd_sat(i_preset[3:0]);
        end else if (i_dec && !w_zero) begin
            if (r_units == 4'd0) begin
                r_units <= BCD_MAX;
                r_tens  <= r_tens - 4'd1;
            end else begin
                r_units <= r_units - 4'd1;
            end
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;
    assign o_zero  = w_zero;
    assign o_one   = (r_tens == 4'd0) && (r_units == 4'd1);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: key sync, 1 Hz prescaler, IDLE/RUN/PAUSE/DONE
// sequencing and DONE blink phase around a 2-digit BCD counter.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_load_n,
    input  logic [7:0] preset,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [1:0] state,
    output logic       tick,
    output logic       done,
    output logic       blink
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic          r_start_s1, r_start_s2, r_start_h;
    logic          r_load_s1, r_load_s2, r_load_h;
    logic [PW-1:0] r_presc;
    logic          r_blink;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start_ev, w_load_ev;
    logic          w_tick, w_load, w_dec;
    logic          w_zero, w_one;
    logic          w_counting;

    // Two-flop synchronizers plus a history flop for falling-edge events.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_start_s1 <= 1'b1;
            r_start_s2 <= 1'b1;
            r_start_h  <= 1'b1;
            r_load_s1  <= 1'b1;
            r_load_s2  <= 1'b1;
            r_load_h   <= 1'b1;
        end else begin
            r_start_s1 <= key_start_n;
            r_start_s2 <= r_start_s1;
            r_start_h  <= r_start_s2;
            r_load_s1  <= key_load_n;
            r_load_s2  <= r_load_s1;
            r_load_h   <= r_load_s2;
        end
    end

    assign w_start_ev = r_start_h & ~r_start_s2;
    assign w_load_ev  = r_load_h & ~r_load_s2;
    assign w_counting = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign w_tick     = w_counting && (r_presc == P_LAST);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, load and decrement strobes; load wins over start.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load_ev)                w_load = 1'b1;
                else if (w_start_ev && !w_zero) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_dec = 1'b1;
                    if (w_one)           w_state_nxt = ST_DONE;
                    else if (w_start_ev) w_state_nxt = ST_PAUSE;
                end else if (w_start_ev) begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_load_ev) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_start_ev) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_load_ev) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_start_ev) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Prescaler: free-runs in RUN/DONE, holds in PAUSE, zeroed in IDLE and on DONE entry.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_state_nxt == ST_IDLE ||
                     (w_state_nxt == ST_DONE && r_state != ST_DONE)) begin
            r_presc <= '0;
        end else if (w_counting) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // Blink starts high on DONE entry, toggles per tick, cleared when leaving.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)                      r_blink <= 1'b0;
        else if (w_state_nxt != ST_DONE) r_blink <= 1'b0;
        else if (r_state != ST_DONE)     r_blink <= 1'b1;
        else if (w_tick)                 r_blink <= ~r_blink;
    end

    bcd_down_counter2 u_cnt (
        .i_clk    (CLOCK_50),
        .i_rst_n  (reset),
        .i_load   (w_load),
        .i_preset (preset),
        .i_dec    (w_dec),
        .o_tens   (bcd1),
        .o_units  (bcd0),
        .o_zero   (w_zero),
        .o_one    (w_one)
    );

    assign state = r_state;
    assign tick  = w_tick;
    assign done  = (r_state == ST_DONE);
    assign blink = r_blink & done;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_start_n;
    logic       key_load_n;
    logic [7:0] preset;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic [1:0] state;
    logic       tick;
    logic       done;
    logic       blink;

    int n_chk  = 0;
    int n_fail = 0;

    countdown_timer_ctrl #(.TICK_DIV(4)) dut (
        .CLOCK_50    (clk),
        .reset       (rst_n),
        .key_start_n (key_start_n),
        .key_load_n  (key_load_n),
        .preset      (preset),
        .bcd1        (bcd1),
        .bcd0        (bcd0),
        .state       (state),
        .tick        (tick),
        .done        (done),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the
    // state update (key sampled at edge k, effect at edge k+2).
    task automatic press(input bit s, input bit l);
        key_start_n = ~s;
        key_load_n  = ~l;
        @(negedge clk);
        key_start_n = 1'b1;
        key_load_n  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        preset = 8'h12;
        press(0, 1);
        press(1, 0);
        repeat (2) @(negedge clk);
        n_chk++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_pre_run: state=%0d want 1", state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd0 || bcd1 !== 4'd0 || bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async: state=%0d bcd=%0d%0d want 0 00",
                     state, bcd1, bcd0);
        end
        n_chk++;
        if (tick !== 1'b0 || done !== 1'b0 || blink !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: tick=%b done=%b blink=%b want 000",
                     tick, done, blink);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_run_to_done();
        int cyc;
        int last;
        int nt;
        bit after3;
        bit fin;
        preset = 8'h12;
        press(0, 1);
        n_chk++;
        if (bcd1 !== 4'd1 || bcd0 !== 4'd2) begin
            n_fail++;
            $display("FAIL load_12: bcd=%0d%0d want 12", bcd1, bcd0);
        end
        press(1, 0);
        cyc = 0; last = -1; nt = 0; after3 = 0; fin = 0;
        for (int j = 0; j < 80 && !fin; j++) begin
            @(negedge clk);
            cyc++;
            if (after3) begin
                after3 = 0;
                n_chk++;
                if (bcd1 !== 4'd0 || bcd0 !== 4'd9) begin
                    n_fail++;
                    $display("FAIL dec_10_09: bcd=%0d%0d want 09", bcd1, bcd0);
                end
            end
            if (tick === 1'b1) begin
                nt++;
                if (last >= 0) begin
                    n_chk++;
                    if (cyc - last !== 4) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0d want 4", cyc - last);
                    end
                end
                last = cyc;
                if (nt == 3) begin
                    after3 = 1;
                    n_chk++;
                    if (bcd1 !== 4'd1 || bcd0 !== 4'd0) begin
                        n_fail++;
                        $display("FAIL pre_dec_10: bcd=%0d%0d want 10", bcd1, bcd0);
                    end
                end
            end
            if (state === 2'd3) fin = 1;
        end
        n_chk++;
        if (!fin) begin
            n_fail++;
            $display("FAIL done_timeout: state=%0d want 3", state);
        end
        n_chk++;
        if (nt !== 12) begin
            n_fail++;
            $display("FAIL tick_count: got %0d want 12", nt);
        end
        n_chk++;
        if (done !== 1'b1 || bcd1 !== 4'd0 || bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL done_out: done=%b bcd=%0d%0d want 1 00",
                     done, bcd1, bcd0);
        end
    endtask

    task automatic test_done_blink();
        bit exp_b;
        for (int i = 0; i < 16; i++) begin
            exp_b = ((i / 4) % 2) == 0;
            n_chk++;
            if (blink !== exp_b || state !== 2'd3) begin
                n_fail++;
                $display("FAIL blink_%0d: blink=%b state=%0d want %b 3",
                         i, blink, state, exp_b);
            end
            @(negedge clk);
        end
        press(1, 0);
        n_chk++;
        if (state !== 2'd0 || bcd1 !== 4'd0 || bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL done_ack: state=%0d bcd=%0d%0d want 0 00",
                     state, bcd1, bcd0);
        end
        n_chk++;
        if (blink !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_flags: blink=%b done=%b want 0 0", blink, done);
        end
    endtask

    task automatic test_sanitise();
        preset = 8'hA5;
        press(0, 1);
        n_chk++;
        if (bcd1 !== 4'd9 || bcd0 !== 4'd5) begin
            n_fail++;
            $display("FAIL sat_A5: bcd=%0d%0d want 95", bcd1, bcd0);
        end
        preset = 8'hFF;
        press(0, 1);
        n_chk++;
        if (bcd1 !== 4'd9 || bcd0 !== 4'd9) begin
            n_fail++;
            $display("FAIL sat_FF: bcd=%0d%0d want 99", bcd1, bcd0);
        end
        preset = 8'h00;
        press(0, 1);
        press(1, 0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (state !== 2'd0 || bcd1 !== 4'd0 || bcd0 !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_start: state=%0d bcd=%0d%0d want 0 00",
                     state, bcd1, bcd0);
        end
    endtask

    task automatic test_pause();
        int nt;
        int wait_c;
        bit bad;
        preset = 8'h05;
        press(0, 1);
        press(1, 0);
        nt = 0;
        for (int j = 0; j < 40 && nt < 2; j++) begin
            @(negedge clk);
            if (tick === 1'b1) nt++;
        end
        n_chk++;
        if (nt !== 2) begin
            n_fail++;
            $display("FAIL pause_ticks: got %0d want 2", nt);
        end
        press(1, 0);
        n_chk++;
        if (state !== 2'd2 || bcd1 !== 4'd0 || bcd0 !== 4'd3) begin
            n_fail++;
            $display("FAIL pause_entry: state=%0d bcd=%0d%0d want 2 03",
                     state, bcd1, bcd0);
        end
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (tick !== 1'b0 || state !== 2'd2 || bcd0 !== 4'd3) bad = 1;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL pause_hold: tick=%b state=%0d bcd0=%0d want 0 2 3",
                     tick, state, bcd0);
        end
        press(1, 0);
        n_chk++;
        if (state !== 2'd1 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: state=%0d tick=%b want 1 0", state, tick);
        end
        wait_c = 0;
        for (int j = 0; j < 10 && tick !== 1'b1; j++) begin
            @(negedge clk);
            wait_c++;
        end
        n_chk++;
        if (wait_c !== 1 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_phase: got %0d cycles want 1", wait_c);
        end
    endtask

    task automatic test_simultaneous();
        press(1, 0);
        n_chk++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL sim_pause: state=%0d want 2", state);
        end
        preset = 8'h37;
        press(1, 1);
        n_chk++;
        if (state !== 2'd0 || bcd1 !== 4'd3 || bcd0 !== 4'd7) begin
            n_fail++;
            $display("FAIL sim_load_wins: state=%0d bcd=%0d%0d want 0 37",
                     state, bcd1, bcd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        key_start_n = 1'b1;
        key_load_n  = 1'b1;
        preset      = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_run_to_done();
        test_done_blink();
        test_sanitise();
        test_pause();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
